aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have parameter NR, default 10, giving the number of AES rounds; legal values are 10, 12 and 14.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  plaintext block offered.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 in_block  input  128  plaintext; byte s0_0 at [7:0], s3_3 at [127:120].
REQ-007 rk_idx  output  4  round-key index requested from the external key store.
REQ-008 rk  input  128  round key for rk_idx, valid combinationally in the same cycle.
REQ-009 rnd_in  output  128  current state register, driven to the external round datapath.
REQ-010 rnd_last  output  1  final round; the datapath omits MixColumns.
REQ-011 rnd_out  input  128  combinational round result: SubBytes, ShiftRows, MixColumns (unless rnd_last), then AddRoundKey with rk.
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  consumer accepts the ciphertext.
REQ-014 out_block  output  128  ciphertext, same byte order as in_block.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-017 In IDLE: in_ready=1, rk_idx=0; when in_valid=1 at a rising edge (the accept edge E0), state_reg SHALL load in_block XOR rk, round counter SHALL load 1, and the FSM SHALL go to ROUND.
REQ-018 In ROUND: rk_idx SHALL equal the round counter; rnd_in SHALL equal state_reg; on each edge, state_reg SHALL load rnd_out and the counter SHALL increment.
REQ-019 rnd_last SHALL be 1 only in ROUND with counter==NR.
REQ-020 On the edge where the counter==NR, the FSM SHALL go to DONE and the counter SHALL return to 0.
REQ-021 Latency: with E0 as the accept edge, round k SHALL complete at edge Ek, and out_valid SHALL first be high in the cycle following edge E(NR).
REQ-022 In DONE: out_valid=1 and out_block=state_reg, held stable until the out handshake; while out_ready=0 neither value may change.
REQ-023 The out handshake (out_valid & out_ready at an edge) SHALL return the FSM to IDLE; in_ready SHALL be 0 in that same DONE cycle, so no accept overlaps the output handshake.
REQ-024 in_ready SHALL be 0 in ROUND and DONE; in_valid and in_block SHALL be ignored there and SHALL NOT disturb state_reg.
REQ-025 The round counter SHALL be 4 bits wide and SHALL never exceed NR; rk_idx SHALL stay in the range 0..NR.
REQ-026 out_block SHALL be driven from state_reg in all states; only out_valid qualifies it.
REQ-027 All outputs SHALL be functions of registered state only, except rnd_in and out_block, which are direct views of state_reg.

Reset
REQ-028 When rst_n=0 the block SHALL immediately enter IDLE with counter=0, state_reg=0, out_valid=0, rnd_last=0 and busy=0; in_ready SHALL read 0 while rst_n=0 and 1 from the first cycle after release.
REQ-029 A reset asserted mid-operation SHALL discard the block in flight; no out_valid SHALL follow for it.

Verification
REQ-030 FIPS-197 C.1 check: key 000102..0f, plaintext 00112233..eeff with first byte at [7:0] -> out_block is 69c4e0d86a7b0430d8cdb78070b4c55a (first byte at [7:0]), out_valid high in the cycle after E10.
REQ-031 rk_idx trace: one accepted block with NR=10 -> rk_idx is 0 at E0, then 1..10 on consecutive cycles; rnd_last is high only while rk_idx=10.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_block is unchanged and in_ready stays 0; the handshake on cycle 6 gives in_ready=1 in the next cycle.
REQ-033 Ignored input: toggle in_valid and in_block throughout ROUND -> ciphertext is identical to REQ-030 and no extra out_valid occurs.
REQ-034 Reset mid-round: drop rst_n while counter=5 -> busy and out_valid fall immediately; after release and a new accept, REQ-030's result is produced with unchanged latency.
REQ-035 Back-to-back: drive two blocks with in_valid held high and out_ready=1 -> the second accept occurs exactly one cycle after the first out handshake.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: drives an external round datapath and
// round-key store, holding one block in flight at a time.
//
// state | meaning
// IDLE  | waiting for a plaintext block; initial AddRoundKey applied on accept
// ROUND | one cipher round per clock, rounds 1..NR
// DONE  | ciphertext held on out_block until the consumer takes it
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] rnd_in,
    output logic         rnd_last,
    input  logic [127:0] rnd_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   rnd_cnt;
    logic [3:0]   rnd_cnt_nxt;
    logic [127:0] state_reg;
    logic [127:0] state_reg_nxt;
    logic         ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rnd_cnt_nxt   = rnd_cnt;
        state_reg_nxt = state_reg;
        case (state)
            IDLE: begin
                if (in_valid && ready_q) begin
                    state_reg_nxt = in_block ^ rk;
                    rnd_cnt_nxt   = 4'd1;
                    state_nxt     = ROUND;
                end
            end
            ROUND: begin
                state_reg_nxt = rnd_out;
                if (rnd_cnt == LAST_RND) begin
                    rnd_cnt_nxt = 4'd0;
                    state_nxt   = DONE;
                end else begin
                    rnd_cnt_nxt = rnd_cnt + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                rnd_cnt_nxt = 4'd0;
            end
        endcase
    end

    // ready is registered so it stays low for the whole reset window and the
    // handshake cycle in DONE, and only rises once IDLE has actually been entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt   <= 4'd0;
            state_reg <= '0;
            ready_q   <= 1'b0;
        end else begin
            rnd_cnt   <= rnd_cnt_nxt;
            state_reg <= state_reg_nxt;
            ready_q   <= (state_nxt == IDLE);
        end
    end

    assign in_ready  = ready_q;
    assign rk_idx    = rnd_cnt;
    assign rnd_in    = state_reg;
    assign rnd_last  = (state == ROUND) && (rnd_cnt == LAST_RND);
    assign out_valid = (state == DONE);
    assign out_block = state_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies an AES-128 key store and round datapath,
// and checks every cycle against a latency-level model of the controller.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_in;
    logic         rnd_last;
    logic [127:0] rnd_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    logic         or_dir = 1'b0;
    logic         rnd_en = 1'b0;
    logic         rnd_bit = 1'b0;
    logic [127:0] rk_tab [0:10];

    int checks = 0;
    int failures = 0;

    bit           m_has_block;
    bit           m_first;
    int           m_age;
    logic [127:0] m_inter [0:10];
    logic [127:0] m_hold;
    int           cyc;
    int           acc_cyc_q[$];
    int           hs_cyc_q[$];

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .rk_idx(rk_idx), .rk(rk), .rnd_in(rnd_in),
        .rnd_last(rnd_last), .rnd_out(rnd_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // ---------------- AES-128 reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} >> (8 - n);
        return t[7:0];
    endfunction

    // S-box from its definition: inverse in GF(2^8) (x^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last);
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(s[8*i +: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[32*c +: 8];
            a1 = sr[32*c+8 +: 8];
            a2 = sr[32*c+16 +: 8];
            a3 = sr[32*c+24 +: 8];
            mc[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return (last ? sr : mc) ^ k;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox(t[8*j +: 8]);
                t[7:0] = t[7:0] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // external key store and round datapath
    assign rk        = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;
    assign rnd_out   = aes_round(rnd_in, rk, rnd_last);
    assign out_ready = rnd_en ? rnd_bit : or_dir;

    initial forever begin
        @(negedge clk);
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model: latency-level view ----------------
    // A block accepted at edge E0 is in round k during the cycle after E(k-1),
    // is presented from the cycle after E(NR), and leaves on an out handshake.
    initial begin
        m_has_block = 1'b0; m_first = 1'b1; m_age = 0; m_hold = '0; cyc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_has_block = 1'b0; m_first = 1'b1; m_age = 0; m_hold = '0;
            end else begin
                cyc++;
                if (!m_has_block) begin
                    if (in_valid && !m_first) begin
                        m_inter[0] = in_block ^ rk_tab[0];
                        for (int r = 1; r <= NR; r++)
                            m_inter[r] = aes_round(m_inter[r-1], rk_tab[r], r == NR);
                        m_has_block = 1'b1;
                        m_age = 1;
                        acc_cyc_q.push_back(cyc);
                    end
                end else if (m_age <= NR) begin
                    m_age++;
                end else if (out_ready) begin
                    m_has_block = 1'b0;
                    m_hold = m_inter[NR];
                    hs_cyc_q.push_back(cyc);
                end
                m_first = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("cmp_in_ready", in_ready, !m_has_block && !m_first);
            if (!m_has_block) begin
                chk("cmp_busy", busy, 0);
                chk("cmp_out_valid", out_valid, 0);
                chk("cmp_rnd_last", rnd_last, 0);
                chk("cmp_rk_idx", rk_idx, 0);
                chk("cmp_idle_block", out_block, m_hold);
            end else if (m_age <= NR) begin
                chk("cmp_busy", busy, 1);
                chk("cmp_out_valid", out_valid, 0);
                chk("cmp_rnd_last", rnd_last, m_age == NR);
                chk("cmp_rk_idx", rk_idx, 128'(m_age));
                chk("cmp_rnd_in", rnd_in, m_inter[m_age-1]);
            end else begin
                chk("cmp_busy", busy, 1);
                chk("cmp_out_valid", out_valid, 1);
                chk("cmp_rnd_last", rnd_last, 0);
                chk("cmp_rk_idx", rk_idx, 0);
                chk("cmp_out_block", out_block, m_inter[NR]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic offer(input logic [127:0] pt);
        int n = 0;
        in_block = pt;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_note("offer_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_note("out_timeout");
        lat = cyc - acc_cyc_q[$];
    endtask

    initial begin
        int n;
        int lat;
        int base;
        int hs0;
        load_key(FIPS_KEY);
        repeat (3) @(negedge clk);

        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rnd_last", rnd_last, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_out_block", out_block, 0);
        #2 rst_n = 1'b1;
        #1 chk("rel_in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", in_ready, 1);

        // FIPS-197 C.1 vector with rk_idx trace
        or_dir = 1'b1;
        chk("trace_rk_idx_e0", rk_idx, 0);
        offer(FIPS_PT);
        for (int k = 1; k <= NR; k++) begin
            chk("trace_rk_idx", rk_idx, 128'(k));
            chk("trace_rnd_last", rnd_last, k == NR);
            @(negedge clk);
        end
        chk("fips_out_valid", out_valid, 1);
        chk("fips_ct", out_block, FIPS_CT);
        chk("fips_latency", 128'(cyc - acc_cyc_q[$]), 10);
        chk("model_fips_ct", m_inter[NR], FIPS_CT);
        @(negedge clk);
        chk("fips_after_hs_valid", out_valid, 0);
        chk("fips_after_hs_ready", in_ready, 1);

        // backpressure: 5 stalled cycles, handshake on the 6th
        or_dir = 1'b0;
        offer(FIPS_PT);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_block", out_block, FIPS_CT);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        or_dir = 1'b1;
        chk("bp_hs_in_ready", in_ready, 0);
        @(negedge clk);
        chk("bp_post_in_ready", in_ready, 1);
        chk("bp_post_out_valid", out_valid, 0);

        // in_valid/in_block noise during ROUND
        offer(FIPS_PT);
        base = acc_cyc_q.size();
        hs0 = hs_cyc_q.size();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_block = rand128();
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_out(lat);
        chk("ign_ct", out_block, FIPS_CT);
        chk("ign_latency", 128'(lat), 10);
        repeat (6) @(negedge clk);
        chk("ign_no_extra_accept", 128'(acc_cyc_q.size()), 128'(base));
        chk("ign_one_output", 128'(hs_cyc_q.size()), 128'(hs0 + 1));

        // reset while the round counter is 5
        offer(FIPS_PT);
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rk_idx != 4'd5) fail_note("mid_reset_wait");
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_block", out_block, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rel_ready", in_ready, 1);
        offer(FIPS_PT);
        wait_out(lat);
        chk("mid_rst_ct", out_block, FIPS_CT);
        chk("mid_rst_latency", 128'(lat), 10);
        @(negedge clk);

        // back-to-back with in_valid held high
        base = acc_cyc_q.size();
        in_block = FIPS_PT;
        in_valid = 1'b1;
        n = 0;
        while (acc_cyc_q.size() < base + 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_block = rand128();
        while (acc_cyc_q.size() < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (acc_cyc_q.size() == base + 2)
            chk("b2b_gap", 128'(acc_cyc_q[$] - hs_cyc_q[$]), 1);
        else
            fail_note("b2b_second_accept");
        wait_out(lat);
        chk("b2b_second_latency", 128'(lat), 10);

        // randomized keys, plaintexts, gaps and out_ready
        rnd_en = 1'b1;
        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                n = 0;
                while (m_has_block && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (m_has_block) fail_note("idle_wait");
                load_key(rand128());
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer(rand128());
        end
        rnd_en = 1'b0;
        or_dir = 1'b1;
        n = 0;
        while (m_has_block && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (m_has_block) fail_note("drain_wait");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
